// File: rtl/pn_pkg.sv
// Shared constants and types for the 63-chip PN run controller.
// Holds the LFSR seed, tap positions and controller state encoding.
package pn_pkg;

  localparam int PN_LEN = 63;
  localparam int PN_TAP_HI = 5;
  localparam int PN_TAP_LO = 4;

  localparam logic [5:0] PN_SEED = 6'h3F;
  // LFSR state at index 62; its successor is the seed
  localparam logic [5:0] PN_END = 6'h1F;

  typedef enum logic [1:0] {
    IDLE,
    SLEW,
    RUN
  } pn_state_e;

endpackage

// File: rtl/pn_lfsr6.sv
// Six-stage Fibonacci LFSR for x^6+x^5+1 with seed load and step.
// The chip is the MSB of the current state.
module pn_lfsr6
  import pn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_seed,
  input  logic       step,
  output logic [5:0] state,
  output logic       chip
);

  always_ff @(posedge clk) begin
    if (rst || load_seed) begin
      state <= PN_SEED;
    end else if (step) begin
      state <= {state[4:0], state[PN_TAP_HI] ^ state[PN_TAP_LO]};
    end
  end

  assign chip = state[PN_TAP_HI];

endmodule

// File: rtl/pn_seq_ctrl.sv
// PN run controller: slew to phase, emit chips every CHIP_DIV clocks.
// Define PN_CTRL_EPOCH_CNT_EN to expose the saturating epoch_cnt port.
module pn_seq_ctrl
  import pn_pkg::*;
#(
  parameter int CHIP_DIV = 2,
  parameter int EPOCH_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [5:0]         cfg_phase,
  input  logic [EPOCH_W-1:0] cfg_epochs,
  output logic               chip,
  output logic               chip_stb,
  output logic [5:0]         chip_idx,
  output logic               epoch,
  output logic               busy,
`ifdef PN_CTRL_EPOCH_CNT_EN
  output logic [EPOCH_W-1:0] epoch_cnt,
`endif
  output logic               done
);

  localparam int DW = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;

  pn_state_e state_q, state_d;

  logic [5:0]         phase_q;
  logic [EPOCH_W-1:0] epochs_q;
  logic [5:0]         idx_q;
  logic [DW-1:0]      div_q;
  logic [5:0]         per_q;
  logic [EPOCH_W-1:0] ep_q;
  logic               last_q;
  logic               done_q;

  logic [5:0]         lfsr_s;
  logic               lfsr_chip;
  logic [5:0]         phase_eff;
  logic [EPOCH_W-1:0] ep_inc;
  logic               accept;
  logic               run;
  logic               div_end;
  logic               stb;
  logic               per_end;
  logic               epoch_i;
  logic               fin_now;
  logic               finish;

  assign phase_eff = (cfg_phase == 6'd63) ? 6'd0 : cfg_phase;
  assign accept = (state_q == IDLE) & start & ~stop & ~done_q;
  assign run = (state_q == RUN);
  assign div_end = (div_q == DW'(CHIP_DIV - 1));
  assign stb = run & (div_q == '0);
  assign per_end = (per_q == 6'(PN_LEN - 1));
  assign epoch_i = stb & per_end;
  assign ep_inc = ep_q + EPOCH_W'(1);
  assign fin_now = epoch_i & (epochs_q != '0) & (ep_inc == epochs_q);
  // Leave RUN where the next strobe would have landed
  assign finish = run & div_end & (last_q | fin_now);

  pn_lfsr6 u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load_seed (accept),
    .step      ((state_q == SLEW) | (run & div_end)),
    .state     (lfsr_s),
    .chip      (lfsr_chip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (phase_eff == 6'd0) ? RUN : SLEW;
        end
      end
      SLEW: begin
        if (stop) begin
          state_d = IDLE;
        end else if (idx_q + 6'd1 == phase_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop || finish) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      epochs_q <= '0;
      idx_q    <= '0;
      div_q    <= '0;
      per_q    <= '0;
      ep_q     <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish & ~stop;
      if (accept) begin
        phase_q  <= phase_eff;
        epochs_q <= cfg_epochs;
        idx_q    <= '0;
        div_q    <= '0;
        per_q    <= '0;
        ep_q     <= '0;
        last_q   <= 1'b0;
      end else if (state_q == SLEW) begin
        idx_q <= idx_q + 6'd1;
      end else if (run) begin
        div_q <= div_end ? '0 : div_q + DW'(1);
        if (div_end) begin
          idx_q <= (lfsr_s == PN_END) ? 6'd0 : idx_q + 6'd1;
        end
        if (stb) begin
          per_q <= per_end ? 6'd0 : per_q + 6'd1;
        end
        if (epoch_i && ep_q != '1) begin
          ep_q <= ep_inc;
        end
        if (fin_now) begin
          last_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy     = (state_q != IDLE);
    chip_stb = stb;
    epoch    = epoch_i;
    chip     = run & lfsr_chip;
    chip_idx = busy ? idx_q : 6'd0;
    done     = done_q & ~stop;
  end

`ifdef PN_CTRL_EPOCH_CNT_EN
  assign epoch_cnt = ep_q;
`endif

endmodule

// File: tb/tb_pn_seq_ctrl.sv
// Directed bench for pn_seq_ctrl at CHIP_DIV=2 and CHIP_DIV=1.
// Chip values come from a bench-side PN table plus literal vectors.
module tb_pn_seq_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic stop;
  logic [5:0] cfg_phase;
  logic [15:0] cfg_epochs;

  logic chip0, stb0, epoch0, busy0, done0;
  logic chip1, stb1, epoch1, busy1, done1;
  logic [5:0] idx0, idx1;
`ifdef PN_CTRL_EPOCH_CNT_EN
  logic [15:0] ecnt0, ecnt1, o_ecnt;
`endif

  logic sel;
  logic o_chip, o_stb, o_epoch, o_busy, o_done;
  logic [5:0] o_idx;

  logic pn_ref [0:62];
  int checks;
  int failures;

  pn_seq_ctrl #(.CHIP_DIV(2), .EPOCH_W(16)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_phase  (cfg_phase),
    .cfg_epochs (cfg_epochs),
    .chip       (chip0),
    .chip_stb   (stb0),
    .chip_idx   (idx0),
    .epoch      (epoch0),
    .busy       (busy0),
`ifdef PN_CTRL_EPOCH_CNT_EN
    .epoch_cnt  (ecnt0),
`endif
    .done       (done0)
  );

  pn_seq_ctrl #(.CHIP_DIV(1), .EPOCH_W(16)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_phase  (cfg_phase),
    .cfg_epochs (cfg_epochs),
    .chip       (chip1),
    .chip_stb   (stb1),
    .chip_idx   (idx1),
    .epoch      (epoch1),
    .busy       (busy1),
`ifdef PN_CTRL_EPOCH_CNT_EN
    .epoch_cnt  (ecnt1),
`endif
    .done       (done1)
  );

  assign o_chip  = sel ? chip1  : chip0;
  assign o_stb   = sel ? stb1   : stb0;
  assign o_idx   = sel ? idx1   : idx0;
  assign o_epoch = sel ? epoch1 : epoch0;
  assign o_busy  = sel ? busy1  : busy0;
  assign o_done  = sel ? done1  : done0;
`ifdef PN_CTRL_EPOCH_CNT_EN
  assign o_ecnt  = sel ? ecnt1  : ecnt0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: busy=%b done=%b want 0 0", o_busy, o_done);
    end
    checks++;
    if (o_chip !== 1'b0 || o_stb !== 1'b0 || o_idx !== 6'd0 || o_epoch !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: chip=%b stb=%b idx=%0d epoch=%b want 0",
               o_chip, o_stb, o_idx, o_epoch);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst(input int ph, input int ep, input int dv, input bit s);
    int eff, n, gap, nep, cyc, total;
    bit got_done;
    logic [11:0] head;
    eff = (ph == 63) ? 0 : ph;
    total = ep * 63;
    n = 0;
    gap = 0;
    nep = 0;
    cyc = 0;
    got_done = 1'b0;
    head = '0;
    sel = s;
    cfg_phase = 6'(ph);
    cfg_epochs = 16'(ep);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise ph=%0d: got %b want 1", ph, o_busy);
    end
    for (int i = 0; i < eff; i++) begin
      checks++;
      if (o_stb !== 1'b0 || o_idx !== 6'(i)) begin
        failures++;
        $display("FAIL slew ph=%0d i=%0d: stb=%b idx=%0d want 0 %0d", ph, i, o_stb, o_idx, i);
      end
      tick();
    end
    checks++;
    if (o_stb !== 1'b1) begin
      failures++;
      $display("FAIL first_stb ph=%0d: got %b want 1 at T+1+%0d", ph, o_stb, eff);
    end
    while (!got_done && cyc < total * dv + 100) begin
      if (o_stb === 1'b1) begin
        if (n > 0) begin
          checks++;
          if (gap != dv) begin
            failures++;
            $display("FAIL spacing n=%0d: got %0d want %0d", n, gap, dv);
          end
        end
        checks++;
        if (o_chip !== pn_ref[(eff + n) % 63] || o_idx !== 6'((eff + n) % 63)) begin
          failures++;
          $display("FAIL chip n=%0d: chip=%b idx=%0d want %b %0d", n, o_chip, o_idx,
                   pn_ref[(eff + n) % 63], (eff + n) % 63);
        end
        checks++;
        if (o_epoch !== ((n % 63) == 62)) begin
          failures++;
          $display("FAIL epoch n=%0d: got %b want %b", n, o_epoch, ((n % 63) == 62));
        end
        if (o_epoch === 1'b1) nep++;
        if (n < 12) head[11 - n] = o_chip;
        n++;
        gap = 0;
      end
      if (o_done === 1'b1) begin
        got_done = 1'b1;
        checks++;
        if (gap != dv || o_busy !== 1'b0 || o_chip !== 1'b0 || o_stb !== 1'b0) begin
          failures++;
          $display("FAIL done_cycle: gap=%0d busy=%b chip=%b stb=%b want %0d 0 0 0",
                   gap, o_busy, o_chip, o_stb, dv);
        end
      end
      tick();
      gap++;
      cyc++;
    end
    checks++;
    if (!got_done || n != total || nep != ep) begin
      failures++;
      $display("FAIL burst_end ph=%0d: done=%b strobes=%0d epochs=%0d want 1 %0d %0d",
               ph, got_done, n, nep, total, ep);
    end
    if (eff == 0) begin
      checks++;
      if (head !== 12'hFC1) begin
        failures++;
        $display("FAIL head: got %b want 111111000001", head);
      end
    end
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b busy=%b want 0 0", o_done, o_busy);
    end
`ifdef PN_CTRL_EPOCH_CNT_EN
    checks++;
    if (o_ecnt !== 16'(ep)) begin
      failures++;
      $display("FAIL epoch_cnt_burst: got %0d want %0d", o_ecnt, ep);
    end
`endif
  endtask

  task automatic test_continuous();
    int n, nep, cyc, extra;
    sel = 1'b0;
    cfg_phase = 6'd0;
    cfg_epochs = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    nep = 0;
    cyc = 0;
    while (n < 200 && cyc < 1000) begin
      if (o_stb === 1'b1) n++;
      if (o_epoch === 1'b1) nep++;
      if (n == 200) stop = 1'b1;
      tick();
      cyc++;
    end
    stop = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_chip !== 1'b0 || o_stb !== 1'b0 || o_idx !== 6'd0) begin
      failures++;
      $display("FAIL stop_out: busy=%b chip=%b stb=%b idx=%0d want 0",
               o_busy, o_chip, o_stb, o_idx);
    end
    checks++;
    if (n != 200 || nep != 3) begin
      failures++;
      $display("FAIL cont_count: strobes=%0d epochs=%0d want 200 3", n, nep);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_done === 1'b1 || o_stb === 1'b1) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL stop_no_done: got %0d done/stb cycles want 0", extra);
    end
`ifdef PN_CTRL_EPOCH_CNT_EN
    checks++;
    if (o_ecnt !== 16'd3) begin
      failures++;
      $display("FAIL epoch_cnt_cont: got %0d want 3", o_ecnt);
    end
`endif
  endtask

  task automatic test_ignore_start();
    int n, bad, cyc;
    bit got_done;
    sel = 1'b0;
    cfg_phase = 6'd0;
    cfg_epochs = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    bad = 0;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 400) begin
      if (cyc == 5) begin
        cfg_phase = 6'd10;
        cfg_epochs = 16'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (o_stb === 1'b1) begin
        if (o_idx !== 6'(n % 63)) bad++;
        n++;
      end
      if (o_done === 1'b1) got_done = 1'b1;
      tick();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!got_done || n != 63) begin
      failures++;
      $display("FAIL ignore_len: done=%b strobes=%0d want 1 63", got_done, n);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ignore_idx: got %0d bad indices want 0", bad);
    end
  endtask

  task automatic test_start_stop();
    int act;
    sel = 1'b0;
    cfg_phase = 6'd0;
    cfg_epochs = 16'd1;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_busy === 1'b1 || o_stb === 1'b1) act++;
      tick();
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL start_stop: got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    cfg_phase = 6'd0;
    cfg_epochs = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_chip !== 1'b0 || o_stb !== 1'b0 || o_idx !== 6'd0 ||
        o_epoch !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: busy=%b chip=%b stb=%b idx=%0d ep=%b done=%b want 0",
               o_busy, o_chip, o_stb, o_idx, o_epoch, o_done);
    end
    rst = 1'b0;
    test_burst(0, 1, 2, 1'b0);
  endtask

  task automatic test_div1();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_burst(63, 2, 1, 1'b1);
  endtask

  initial begin
    logic [5:0] s;
    checks = 0;
    failures = 0;
    sel = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_phase = 6'd0;
    cfg_epochs = 16'd0;
    s = 6'h3F;
    for (int i = 0; i < 63; i++) begin
      pn_ref[i] = s[5];
      s = {s[4:0], s[5] ^ s[4]};
    end
    test_reset();
    test_burst(0, 1, 2, 1'b0);
    test_burst(6, 2, 2, 1'b0);
    test_continuous();
    test_ignore_start();
    test_start_stop();
    test_reset_mid();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
